// File: rtl/core_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWR  = 4'd5,
    S_MEMWB  = 4'd6,
    S_EXECR  = 4'd7,
    S_EXECI  = 4'd8,
    S_ALUWB  = 4'd9,
    S_BRANCH = 4'd10,
    S_JAL    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle.
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       memReady;
  logic       memReq;
  logic       memWrite;
  logic       adrSrc;
  logic       irWrite;
  logic       pcWrite;
  logic       regWrite;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       immOp;
  logic [1:0] resultSrc;
  logic       instrDone;
  logic       illegal;

  modport master (
    input  opcode, funct3, zero, memReady,
    output memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           aluSrcA, aluSrcB, aluOp, immOp, resultSrc, instrDone, illegal
  );

  modport slave (
    output opcode, funct3, zero, memReady,
    input  memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
           aluSrcA, aluSrcB, aluOp, immOp, resultSrc, instrDone, illegal
  );
endinterface

// File: rtl/ctrl_output_decode.sv
// Moore output decode from FSM state; only the fetch strobes, MEMWR done
// and branch pcWrite look at inputs.
module ctrl_output_decode
  import core_ctrl_pkg::*;
(
  input  state_t     state_i,
  input  logic       zero_i,
  input  logic       funct3_0_i,
  input  logic       memReady_i,
  output logic       memReq_o,
  output logic       memWrite_o,
  output logic       adrSrc_o,
  output logic       irWrite_o,
  output logic       pcWrite_o,
  output logic       regWrite_o,
  output logic [1:0] aluSrcA_o,
  output logic [1:0] aluSrcB_o,
  output logic [1:0] aluOp_o,
  output logic       immOp_o,
  output logic [1:0] resultSrc_o,
  output logic       instrDone_o
);

  // Per-state control values; anything not set stays 0.
  always_comb begin
    memReq_o    = 1'b0;
    memWrite_o  = 1'b0;
    adrSrc_o    = 1'b0;
    irWrite_o   = 1'b0;
    pcWrite_o   = 1'b0;
    regWrite_o  = 1'b0;
    aluSrcA_o   = '0;
    aluSrcB_o   = '0;
    aluOp_o     = '0;
    immOp_o     = 1'b0;
    resultSrc_o = '0;
    instrDone_o = 1'b0;
    case (state_i)
      S_FETCH: begin
        memReq_o    = 1'b1;
        aluSrcA_o   = SRCA_PC;
        aluSrcB_o   = SRCB_FOUR;
        aluOp_o     = ALUOP_ADD;
        resultSrc_o = RES_ALU;
        irWrite_o   = memReady_i;
        pcWrite_o   = memReady_i;
      end
      S_DECODE: begin
        aluSrcA_o = SRCA_OLDPC;
        aluSrcB_o = SRCB_IMM;
        aluOp_o   = ALUOP_ADD;
      end
      S_MEMADR: begin
        aluSrcA_o = SRCA_REGA;
        aluSrcB_o = SRCB_IMM;
        aluOp_o   = ALUOP_ADD;
      end
      S_MEMRD: begin
        memReq_o = 1'b1;
        adrSrc_o = 1'b1;
      end
      S_MEMWR: begin
        memReq_o    = 1'b1;
        memWrite_o  = 1'b1;
        adrSrc_o    = 1'b1;
        instrDone_o = memReady_i;
      end
      S_MEMWB: begin
        resultSrc_o = RES_MEMDATA;
        regWrite_o  = 1'b1;
        instrDone_o = 1'b1;
      end
      S_EXECR: begin
        aluSrcA_o = SRCA_REGA;
        aluSrcB_o = SRCB_REGB;
        aluOp_o   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        aluSrcA_o = SRCA_REGA;
        aluSrcB_o = SRCB_IMM;
        aluOp_o   = ALUOP_FUNCT;
        immOp_o   = 1'b1;
      end
      S_ALUWB: begin
        resultSrc_o = RES_ALUOUT;
        regWrite_o  = 1'b1;
        instrDone_o = 1'b1;
      end
      S_BRANCH: begin
        aluSrcA_o   = SRCA_REGA;
        aluSrcB_o   = SRCB_REGB;
        aluOp_o     = ALUOP_SUB;
        resultSrc_o = RES_ALUOUT;
        instrDone_o = 1'b1;
        pcWrite_o   = zero_i ^ funct3_0_i;
      end
      S_JAL: begin
        aluSrcA_o   = SRCA_OLDPC;
        aluSrcB_o   = SRCB_FOUR;
        aluOp_o     = ALUOP_ADD;
        resultSrc_o = RES_ALUOUT;
        pcWrite_o   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
module multicycle_controller
  import core_ctrl_pkg::*;
(
  input logic                     clk,
  input logic                     rst_n,
  multicycle_controller_if.master bus
);

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;

  // Next-state selection; an unsupported opcode in DECODE flags illegal
  // and restarts fetch.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.memReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.memReady) state_d = S_MEMWB;
      S_MEMWR:  if (bus.memReady) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_JAL:    state_d = S_ALUWB;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and registered illegal pulse (lands in the cycle after DECODE).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.illegal = illegal_q;

  ctrl_output_decode u_decode (
    .state_i     (state_q),
    .zero_i      (bus.zero),
    .funct3_0_i  (bus.funct3[0]),
    .memReady_i  (bus.memReady),
    .memReq_o    (bus.memReq),
    .memWrite_o  (bus.memWrite),
    .adrSrc_o    (bus.adrSrc),
    .irWrite_o   (bus.irWrite),
    .pcWrite_o   (bus.pcWrite),
    .regWrite_o  (bus.regWrite),
    .aluSrcA_o   (bus.aluSrcA),
    .aluSrcB_o   (bus.aluSrcB),
    .aluOp_o     (bus.aluOp),
    .immOp_o     (bus.immOp),
    .resultSrc_o (bus.resultSrc),
    .instrDone_o (bus.instrDone)
  );

endmodule
